// File: rtl/conv3x3_relu_unit.sv
// Streaming 3x3 valid convolution with bias, ReLU, right-shift requantization
// and unsigned 8-bit saturation. Accepts a pre-padded raster frame one pixel
// per valid cycle and emits the (IN_W-2) x (IN_H-2) result stream two edges
// after each window's bottom-right pixel is accepted.
module conv3x3_relu_unit #(
  parameter int IN_W      = 30,
  parameter int IN_H      = 30,
  parameter int OUT_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic [71:0] weights,
  input  logic [15:0] bias,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last
);

  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;

  // Frame position of the pixel currently presented on in_data
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end, row_end, first_px, win_ok;

  // Line buffers: lb_mid holds the previous row, lb_top the row before it
  logic [7:0] lb_mid [IN_W];
  logic [7:0] lb_top [IN_W];

  // 3x3 window, index k = 3*row + col, k=8 is the bottom-right tap
  logic [7:0] win [9];

  // Per-frame coefficients, frozen at pixel (0,0)
  logic [7:0]  w_sh [9];
  logic [15:0] b_sh;

  // Pipeline: window stage -> product stage -> output register
  logic               win_v, win_l;
  logic               prod_v, prod_l;
  logic signed [16:0] prod [9];
  logic signed [15:0] prod_b;

  // Requantization datapath
  logic signed [21:0] acc, shifted;
  logic [7:0]         res;

  assign col_end  = (col == CW'(IN_W - 1));
  assign row_end  = (row == RW'(IN_H - 1));
  assign first_px = in_valid && (col == '0) && (row == '0);
  assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));

  // Control state: counters, valid/last pipeline, shadow coefficients, outputs
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what lets the product stage still see
  // the old shadow weights on the edge that loads the next frame's weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      win_v     <= 1'b0;
      win_l     <= 1'b0;
      prod_v    <= 1'b0;
      prod_l    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      b_sh      <= '0;
      for (int k = 0; k < 9; k++) w_sh[k] <= '0;
    end else begin
      if (in_valid) begin
        col <= col_end ? '0 : col + CW'(1);
        if (col_end) row <= row_end ? '0 : row + RW'(1);
      end
      if (first_px) begin
        b_sh <= bias;
        for (int k = 0; k < 9; k++) w_sh[k] <= weights[8*k +: 8];
      end
      win_v     <= in_valid && win_ok;
      win_l     <= in_valid && col_end && row_end;
      prod_v    <= win_v;
      prod_l    <= win_v && win_l;
      out_valid <= prod_v;
      out_last  <= prod_v && prod_l;
      if (prod_v) out_data <= res;
    end
  end

  // Datapath storage: line buffers, window shift and product registers
  // NOTE: line buffers and data registers carry no reset; the counters and
  // valid bits guarantee stale contents never reach a valid result, and
  // leaving them unreset lets the buffers map onto plain RAM.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= in_data;
      win[0] <= win[1];  win[1] <= win[2];  win[2] <= lb_top[col];
      win[3] <= win[4];  win[4] <= win[5];  win[5] <= lb_mid[col];
      win[6] <= win[7];  win[7] <= win[8];  win[8] <= in_data;
    end
    // Bias travels with its products so a new frame's shadow load cannot
    // leak into the previous frame's last result.
    prod_b <= b_sh;
    for (int k = 0; k < 9; k++)
      prod[k] <= $signed({9'b0, win[k]}) * $signed({{9{w_sh[k][7]}}, w_sh[k]});
  end

  // Accumulate, ReLU, shift and saturate to unsigned 8 bits
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    acc = {{6{prod_b[15]}}, prod_b};
    for (int k = 0; k < 9; k++) acc = acc + {{5{prod[k][16]}}, prod[k]};
    shifted = acc >>> OUT_SHIFT;
    res     = '0;
    if (acc[21])                res = '0;
    else if (shifted > 22'sd255) res = 8'd255;
    else                        res = shifted[7:0];
  end

endmodule

// File: tb/tb_conv3x3_relu_unit.sv
// Scoreboard bench for conv3x3_relu_unit. Three instances share the input
// stream and differ only in OUT_SHIFT (0, 3, 6). The driver computes each
// window sum straight from the stored image and pushes it with its due cycle;
// a negedge monitor pops per instance and compares data, last flag and timing.
module tb_conv3x3_relu_unit;

  localparam int W = 30;
  localparam int H = 30;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic [71:0] weights = '0;
  logic [15:0] bias = '0;
  logic [7:0]  od [3];
  logic        ov [3];
  logic        ol [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv3x3_relu_unit #(.IN_W(W), .IN_H(H), .OUT_SHIFT(g * 3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .weights  (weights),
      .bias     (bias),
      .out_data (od[g]),
      .out_valid(ov[g]),
      .out_last (ol[g])
    );
  end

  typedef struct {
    int     acc;
    bit     last;
    longint due;
  } exp_t;

  exp_t   exp_list[$];
  int     rd [3] = '{0, 0, 0};
  int     img [H][W];
  longint cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ReLU, truncating right shift, saturate to 0..255
  function automatic int requant(input int acc, input int sh);
    int v;
    if (acc < 0) return 0;
    v = acc >>> sh;
    return (v > 255) ? 255 : v;
  endfunction

  // Window sum with the bottom-right tap at (r, c)
  function automatic int win_acc(input int r, input int c,
                                 input logic [71:0] w, input logic [15:0] b);
    int s;
    logic [7:0] t;
    s = int'($signed(b));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        t = w[8*(3*i+j) +: 8];
        s += img[r-2+i][c-2+j] * int'($signed(t));
      end
    return s;
  endfunction

  // Monitor: pop and compare whenever an instance presents a result
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ov[g]) begin
        if (rd[g] >= exp_list.size()) begin
          check($sformatf("unexpected_out[sh%0d]", g * 3), 1, 0);
        end else begin
          check($sformatf("data[sh%0d]#%0d", g * 3, rd[g]), od[g],
                requant(exp_list[rd[g]].acc, g * 3));
          check($sformatf("last[sh%0d]#%0d", g * 3, rd[g]), ol[g],
                exp_list[rd[g]].last);
          check($sformatf("latency[sh%0d]#%0d", g * 3, rd[g]), cyc,
                exp_list[rd[g]].due);
          rd[g]++;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_list.delete();
    rd = '{0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_data[%0d]", g), od[g], 0);
      check($sformatf("rst_valid[%0d]", g), ov[g], 0);
      check($sformatf("rst_last[%0d]", g), ol[g], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // mode 0: i%256 ramp, 1: constant cval, 2: random pixels.
  // Weights/bias are applied with pixel (0,0); afterwards the ports are
  // scrambled so only the shadowed values may influence the frame.
  task automatic run_frame(input int mode, input int cval, input logic [71:0] w,
                           input logic [15:0] b, input int gap, input int stop);
    int r, c;
    for (int i = 0; i < NPIX; i++)
      img[i / W][i % W] = (mode == 0) ? (i % 256) :
                          (mode == 1) ? cval : int'($urandom_range(255));
    for (int i = 0; i < stop; i++) begin
      r = i / W;
      c = i % W;
      while (gap > 0 && int'($urandom_range(99)) < gap) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'(img[r][c]);
      if (i == 0) begin
        weights = w;
        bias    = b;
      end else begin
        weights = {8'($urandom), $urandom, $urandom};
        bias    = 16'($urandom);
      end
      if (r >= 2 && c >= 2)
        exp_list.push_back('{acc: win_acc(r, c, w, b),
                             last: (r == H - 1 && c == W - 1),
                             due: cyc + 3});
    end
  endtask

  function automatic logic [71:0] rand_taps();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    logic [71:0] ident, negi, ones, p127, m128;
    int          budget;
    ident = {32'h0, 8'h01, 32'h0};
    negi  = {32'h0, 8'hFF, 32'h0};
    ones  = {9{8'h01}};
    p127  = {9{8'h7F}};
    m128  = {9{8'h80}};

    do_reset();
    idle(2);

    run_frame(0, 0,   ident, 16'd0,      0,  NPIX);  // identity ramp
    run_frame(1, 100, ones,  16'd0,      0,  NPIX);  // box sum
    run_frame(1, 40,  ident, 16'hFFCE,   0,  NPIX);  // bias -50 -> 0
    run_frame(1, 60,  ident, 16'hFFCE,   0,  NPIX);  // bias -50 -> 10
    run_frame(2, 0,   negi,  16'd0,      0,  NPIX);  // negative tap -> 0
    run_frame(1, 255, p127,  16'h7FFF,   0,  NPIX);  // max positive
    run_frame(1, 255, m128,  16'h8000,   0,  NPIX);  // max negative
    run_frame(2, 0,   rand_taps(), 16'(int'($urandom_range(2000)) - 1000), 30, NPIX);
    idle(6);

    // Mid-frame reset, then two frames back to back with different weights
    run_frame(2, 0, rand_taps(), 16'd0, 0, 400);
    do_reset();
    idle(4);
    check("no_out_after_reset", rd[0] + rd[1] + rd[2], 0);
    run_frame(2, 0, rand_taps(), 16'(int'($urandom_range(2000)) - 1000), 0, NPIX);
    run_frame(2, 0, rand_taps(), 16'(int'($urandom_range(2000)) - 1000), 0, NPIX);
    idle(1);

    budget = 0;
    while ((rd[0] < exp_list.size() || rd[1] < exp_list.size() ||
            rd[2] < exp_list.size()) && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    idle(3);
    for (int g = 0; g < 3; g++)
      check($sformatf("result_count[sh%0d]", g * 3), rd[g], exp_list.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv3x3_relu_unit.md
Name: conv3x3_relu_unit

Overview:
- Streaming 3x3 valid convolution with bias, ReLU, right-shift requantization and 8-bit saturation.
- Sits directly upstream of max_pool_unit. Takes a pre-padded IN_W x IN_H single-channel frame in raster order, one pixel per accepted cycle.
- Emits an (IN_W-2) x (IN_H-2) raster stream in the same valid-qualified format the pooling stage consumes (30x30 in -> 28x28 out).
- Uses two internal line buffers plus a 3x3 window register, so no frame storage is needed.

Parameters:
IN_W, 30, input frame width in pixels (>=3)
IN_H, 30, input frame height in pixels (>=3)
OUT_SHIFT, 0, arithmetic right shift applied after ReLU (0..15)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_data  input  8  unsigned input pixel
in_valid  input  1  pixel qualifier; no backpressure, pixel accepted every edge it is high
weights  input  72  nine signed 8-bit taps; w[k] = weights[8k+7:8k], k=0 top-left .. k=8 bottom-right, row-major
bias  input  16  signed bias added to the 9-tap sum
out_data  output  8  unsigned result pixel
out_valid  output  1  out_data qualifier, high one cycle per result
out_last  output  1  high together with out_valid on the final result of a frame

Behaviour:
- Reset state (async assert): out_data=0, out_valid=0, out_last=0.
  - Row and column counters = 0; all pipeline valid bits = 0; weight/bias shadow registers = 0.
  - Line buffer contents are not cleared and are don't-care, because the counters restart.
- Counters advance only on accepted pixels.
  - col runs 0..IN_W-1, then wraps to 0 and row increments.
  - After pixel (IN_H-1, IN_W-1), both counters wrap to 0, so the next frame starts immediately with no idle cycle required.
- Shadow registers: weights and bias are captured into shadow registers on the edge that accepts pixel (0,0) of each frame. The frame uses only the shadow values, and port changes mid-frame have no effect.
- Window: each accepted pixel shifts into the 3x3 window together with the two line-buffer outputs for the same column, and is written into the line buffers.
- A window is valid when the accepted pixel has row>=2 and col>=2. That pixel is the window's bottom-right tap.
- Pipeline, for a pixel accepted at edge k:
  - edge k+1: nine products (8u x 8s -> 17-bit signed) are registered.
  - edge k+2: out_data and out_valid are registered.
  - Fixed latency is 2 edges. The pipeline advances every cycle regardless of in_valid, so gaps in in_valid appear as gaps in out_valid and never stall in-flight results.
- Arithmetic: acc = sum of 9 products + sign-extended bias, held in 22-bit signed.
  - If acc<0, result = 0.
  - Otherwise v = acc >> OUT_SHIFT (truncation); result = 255 if v>255, else v[7:0].
- out_valid is low in every cycle without a result; out_data holds its last value while out_valid is low.
- out_last is asserted with the result whose window bottom-right tap is pixel (IN_H-1, IN_W-1).
- Output count per frame is exactly (IN_W-2)*(IN_H-2), in raster order.
- Reset mid-frame: in-flight results are discarded (no out_valid after reset). The next accepted pixel is treated as (0,0) of a new frame.
- Back-to-back frames: a result of frame N is still in the pipeline while frame N+1 row 0 is being accepted. This is correct because rows 0..1 never produce windows and the shadow registers load at (0,0) only after the product stage has taken frame N's last taps.

Test Plan:
- Identity kernel: w4=1, others 0, bias=0, OUT_SHIFT=0; input i%256 over 30x30 -> 784 outputs; output #0 = 31 (pixel (1,1)); output #n = pixel at (n/28+1, n%28+1) mod 256; out_last only on #783.
- Box sum: all taps 1, bias 0, OUT_SHIFT=3, constant input 100 -> every output 112. Same with OUT_SHIFT=0 -> every output 255 (900 saturates).
- ReLU and bias: identity kernel, bias=-50; input constant 40 -> all 0; input constant 60 -> all 10. Kernel w4=-1, bias 0 -> all 0.
- Saturation extreme: all taps 127, bias 32767, input 255 -> all 255. All taps -128, bias -32768 -> all 0, with no wrap-around artifacts.
- Random image and random taps with OUT_SHIFT=6; in_valid deasserted randomly ~30% of cycles -> outputs match the golden model; 784 results; latency from each bottom-right acceptance is exactly 2 edges.
- Reset mid-frame after 400 pixels, then a full frame followed immediately by a second frame with changed weights applied at (0,0) -> no out_valid after reset; each frame gives 784 correct results using its own weights; one out_last per frame.
